// File: rtl/dmem_responder.sv
// Single-port data-memory responder with a valid/ready request channel and a
// valid/ready response channel. It serves one access at a time, with a
// configurable number of wait states before the response appears.
module dmem_responder #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_mode,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  mode_q, mode_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem [DEPTH];

    logic [31:0] cur_addr;
    logic [3:0]  cur_mode;
    logic [31:0] cur_wdata;
    logic [2:0]  f3;
    logic        is_wr;
    logic        cur_err;
    logic [AW-1:0] idx;
    logic [31:0] rd_word;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_data;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic        commit;
    logic        mem_we;

    assign req_ready = (state_q == IDLE) && !rst;
    assign rsp_valid = (state_q == RESP) && !rst;
    assign rsp_rdata = rst ? 32'h0 : rdata_q;
    assign rsp_err   = rst ? 1'b0  : err_q;

    // Access decode: in IDLE the request is still on the inputs (zero-wait
    // accepts commit on the same edge), afterwards the latched copy is used.
    always_comb begin
        cur_addr  = (state_q == IDLE) ? req_addr  : addr_q;
        cur_mode  = (state_q == IDLE) ? req_mode  : mode_q;
        cur_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
        f3        = cur_mode[2:0];
        is_wr     = cur_mode[3];
        idx       = cur_addr[AW+1:2];

        cur_err = 1'b0;
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) cur_err = 1'b1;
        if (is_wr && f3[2])                               cur_err = 1'b1;
        if (f3[1:0] == 2'b01 && cur_addr[0])              cur_err = 1'b1;
        if (f3 == 3'b010 && cur_addr[1:0] != 2'b00)       cur_err = 1'b1;
        if ({2'b00, cur_addr[31:2]} >= 32'(DEPTH))        cur_err = 1'b1;

        rd_word = mem[idx];
        case (cur_addr[1:0])
            2'd0:    rd_byte = rd_word[7:0];
            2'd1:    rd_byte = rd_word[15:8];
            2'd2:    rd_byte = rd_word[23:16];
            default: rd_byte = rd_word[31:24];
        endcase
        rd_half = cur_addr[1] ? rd_word[31:16] : rd_word[15:0];

        case (f3)
            3'b000:  load_data = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
            3'b100:  load_data = {24'h0, rd_byte};
            3'b101:  load_data = {16'h0, rd_half};
            default: load_data = rd_word;
        endcase

        case (f3[1:0])
            2'b00: begin
                wr_data = {4{cur_wdata[7:0]}};
                wr_be   = 4'b0001 << cur_addr[1:0];
            end
            2'b01: begin
                wr_data = {2{cur_wdata[15:0]}};
                wr_be   = cur_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                wr_data = cur_wdata;
                wr_be   = 4'b1111;
            end
        endcase
    end

    // Next-state logic: accept, count wait states, commit on entry to RESP.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        mode_d  = mode_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    mode_d  = req_mode;
                    wdata_d = req_wdata;
                    cnt_d   = 4'd0;
                    if (WAIT_CYCLES > 0) begin
                        state_d = WAIT;
                    end else begin
                        state_d = RESP;
                        commit  = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    state_d = RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (commit) begin
            err_d   = cur_err;
            rdata_d = (cur_err || is_wr) ? 32'h0 : load_data;
        end
    end

    assign mem_we = commit && is_wr && !cur_err && !rst;

    // Control and response registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'h0;
            mode_q  <= 4'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            mode_q  <= mode_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Memory array with per-byte write enables; contents survive reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (mem_we && wr_be[i]) mem[idx][8*i +: 8] <= wr_data[8*i +: 8];
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a table of sequential accesses on a
// one-wait-state instance, hand-written backpressure/reset sequences, and a
// zero-wait-state instance for back-to-back throughput.
module tb_dmem_responder;

    logic        clk;
    logic        rst;
    logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
    logic [31:0] req_addr, req_wdata, rsp_rdata;
    logic [3:0]  req_mode;

    logic        req_valid0, req_ready0, rsp_valid0, rsp_ready0, rsp_err0;
    logic [31:0] req_addr0, req_wdata0, rsp_rdata0;
    logic [3:0]  req_mode0;

    int pass_count = 0;
    int total_count = 0;

    typedef struct {
        logic        w;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_mode(req_mode), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err)
    );

    dmem_responder #(.DEPTH(64), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid0), .req_ready(req_ready0), .req_addr(req_addr0),
        .req_mode(req_mode0), .req_wdata(req_wdata0),
        .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0), .rsp_rdata(rsp_rdata0),
        .rsp_err(rsp_err0)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, actual, expected);
        end
    endtask

    // Issue one request on the one-wait instance and return the response plus
    // the number of cycles from accept to rsp_valid.
    task automatic applyStimulus(input logic w, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] d, output logic [31:0] rd,
                                 output logic er, output int lat);
        int n;
        @(negedge clk);
        req_valid = 1'b1;
        req_mode  = {w, f3};
        req_addr  = a;
        req_wdata = d;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            req_valid = 1'b0;
            rd  = 32'h0;
            er  = 1'b0;
            lat = -1;
        end else begin
            @(negedge clk);
            req_valid = 1'b0;
            req_mode  = 4'b1010;
            req_addr  = 32'h0000_0010;
            req_wdata = 32'h0;
            lat = 1;
            while (!rsp_valid && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            rd = rsp_rdata;
            er = rsp_err;
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;

        rst        = 1'b1;
        req_valid  = 1'b0;
        req_addr   = 32'h0;
        req_mode   = 4'h0;
        req_wdata  = 32'h0;
        rsp_ready  = 1'b1;
        req_valid0 = 1'b0;
        req_addr0  = 32'h0;
        req_mode0  = 4'h0;
        req_wdata0 = 32'h0;
        rsp_ready0 = 1'b1;

        vecs.push_back('{1'b1, 3'b010, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 3'b010, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0});
        vecs.push_back('{1'b1, 3'b010, 32'h20,   32'h11223344, 32'h0,        1'b0});
        vecs.push_back('{1'b1, 3'b000, 32'h21,   32'hABCDEF80, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 3'b000, 32'h21,   32'h0,        32'hFFFFFF80, 1'b0});
        vecs.push_back('{1'b0, 3'b100, 32'h21,   32'h0,        32'h00000080, 1'b0});
        vecs.push_back('{1'b0, 3'b010, 32'h20,   32'h0,        32'h11228044, 1'b0});
        vecs.push_back('{1'b0, 3'b001, 32'h13,   32'h0,        32'h0,        1'b1});
        vecs.push_back('{1'b1, 3'b010, 32'h22,   32'h55555555, 32'h0,        1'b1});
        vecs.push_back('{1'b1, 3'b100, 32'h20,   32'hFFFFFFFF, 32'h0,        1'b1});
        vecs.push_back('{1'b0, 3'b010, 32'h1000, 32'h0,        32'h0,        1'b1});
        vecs.push_back('{1'b1, 3'b010, 32'h1010, 32'h0,        32'h0,        1'b1});
        vecs.push_back('{1'b1, 3'b001, 32'h21,   32'h0000FFFF, 32'h0,        1'b1});
        vecs.push_back('{1'b0, 3'b010, 32'h20,   32'h0,        32'h11228044, 1'b0});
        vecs.push_back('{1'b0, 3'b010, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0});
        vecs.push_back('{1'b1, 3'b001, 32'h12,   32'h1234A5C3, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 3'b010, 32'h10,   32'h0,        32'hA5C3BEEF, 1'b0});
        vecs.push_back('{1'b0, 3'b001, 32'h12,   32'h0,        32'hFFFFA5C3, 1'b0});
        vecs.push_back('{1'b0, 3'b101, 32'h12,   32'h0,        32'h0000A5C3, 1'b0});
        vecs.push_back('{1'b0, 3'b000, 32'h13,   32'h0,        32'hFFFFFFA5, 1'b0});
        vecs.push_back('{1'b0, 3'b100, 32'h10,   32'h0,        32'h000000EF, 1'b0});
        vecs.push_back('{1'b0, 3'b001, 32'h22,   32'h0,        32'h00001122, 1'b0});
        vecs.push_back('{1'b0, 3'b011, 32'h10,   32'h0,        32'h0,        1'b1});
        vecs.push_back('{1'b0, 3'b110, 32'h10,   32'h0,        32'h0,        1'b1});
        vecs.push_back('{1'b0, 3'b111, 32'h10,   32'h0,        32'h0,        1'b1});
        vecs.push_back('{1'b1, 3'b010, 32'h40,   32'hCAFEF00D, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 3'b010, 32'h10,   32'h0,        32'hA5C3BEEF, 1'b0});

        // Reset values while rst is held.
        repeat (3) @(negedge clk);
        checkOutput("reset req_ready", {31'h0, req_ready}, 32'h0);
        checkOutput("reset rsp_valid", {31'h0, rsp_valid}, 32'h0);
        checkOutput("reset rsp_rdata", rsp_rdata, 32'h0);
        checkOutput("reset rsp_err",   {31'h0, rsp_err}, 32'h0);
        checkOutput("reset rsp_valid0", {31'h0, rsp_valid0}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post-reset req_ready", {31'h0, req_ready}, 32'h1);
        checkOutput("post-reset req_ready0", {31'h0, req_ready0}, 32'h1);

        // Sequential access table.
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].w, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, er, lat);
            checkOutput($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rdata);
            checkOutput($sformatf("vec%0d err", i), {31'h0, er}, {31'h0, vecs[i].exp_err});
            checkOutput($sformatf("vec%0d latency", i), 32'(lat), 32'd2);
        end

        // Backpressure: response held for five cycles.
        rsp_ready = 1'b0;
        applyStimulus(1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat);
        for (int k = 0; k < 5; k++) begin
            checkOutput($sformatf("hold%0d rsp_valid", k), {31'h0, rsp_valid}, 32'h1);
            checkOutput($sformatf("hold%0d rsp_rdata", k), rsp_rdata, 32'hA5C3BEEF);
            checkOutput($sformatf("hold%0d req_ready", k), {31'h0, req_ready}, 32'h0);
            if (k < 4) @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        checkOutput("release rsp_valid", {31'h0, rsp_valid}, 32'h0);
        checkOutput("release req_ready", {31'h0, req_ready}, 32'h1);
        checkOutput("release rdata held", rsp_rdata, 32'hA5C3BEEF);

        // Reset during WAIT of a store to 0x40.
        req_valid = 1'b1;
        req_mode  = 4'b1010;
        req_addr  = 32'h40;
        req_wdata = 32'h12345678;
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("wait-reset rsp_valid", {31'h0, rsp_valid}, 32'h0);
        checkOutput("wait-reset req_ready", {31'h0, req_ready}, 32'h0);
        rst = 1'b0;
        begin
            int seen = 0;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                if (rsp_valid) seen++;
            end
            checkOutput("wait-reset no response", 32'(seen), 32'd0);
        end
        applyStimulus(1'b0, 3'b010, 32'h40, 32'h0, rd, er, lat);
        checkOutput("wait-reset mem 0x40", rd, 32'hCAFEF00D);
        checkOutput("wait-reset err", {31'h0, er}, 32'h0);

        // Reset during RESP drops rsp_valid without a handshake.
        rsp_ready = 1'b0;
        applyStimulus(1'b0, 3'b010, 32'h20, 32'h0, rd, er, lat);
        checkOutput("resp-reset pre rsp_valid", {31'h0, rsp_valid}, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("resp-reset rsp_valid", {31'h0, rsp_valid}, 32'h0);
        checkOutput("resp-reset rsp_rdata", rsp_rdata, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("resp-reset after rsp_valid", {31'h0, rsp_valid}, 32'h0);
        checkOutput("resp-reset after req_ready", {31'h0, req_ready}, 32'h1);
        rsp_ready = 1'b1;

        // Zero-wait instance: back-to-back stores, one accept every 2 cycles.
        req_valid0 = 1'b1;
        req_mode0  = 4'b1010;
        req_addr0  = 32'h8;
        req_wdata0 = 32'h1;
        rsp_ready0 = 1'b1;
        for (int i = 0; i < 12; i++) begin
            checkOutput($sformatf("zw%0d accept", i), {31'h0, req_valid0 & req_ready0},
                        (i % 2 == 0) ? 32'h1 : 32'h0);
            checkOutput($sformatf("zw%0d rsp_valid", i), {31'h0, rsp_valid0},
                        (i % 2 == 1) ? 32'h1 : 32'h0);
            @(negedge clk);
        end
        req_valid0 = 1'b0;

        $display("%0d/%0d checks passed", pass_count, total_count);
        $finish;
    end

endmodule
